ctrl_pipe: RTL

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pkg.sv | 41 ++++
 rtl/ctrl_pipe_main_decoder.sv | 63 ++++++
 rtl/ctrl_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the in-order pipeline control block: opcodes, ALU op
// encoding, the ID/EX control bundle and the memory-wait FSM states.
package ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ADD   = 2'b00,
    BR    = 2'b01,
    FUNCT = 2'b10,
    PASS  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    ALUSrc;
    logic    MemtoReg;
    logic    RegWrite;
    logic    MemRead;
    logic    MemWrite;
    alu_op_e ALUOp;
    logic    Branch;
    logic    Jump;
    logic    Illegal;
  } ctrl_t;

  typedef enum logic {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_e;

endpackage

// File: rtl/ctrl_pipe_main_decoder.sv
// Combinational main decoder: opcode to control bundle. Jump-class opcodes
// decode only when EN_JUMP is set; anything unrecognised flags Illegal.
module main_decoder
  import ctrl_pkg::*;
#(
  parameter bit EN_JUMP = 1'b1
) (
  input  logic [6:0] i_opcode,
  output ctrl_t      o_ctrl
);

  // Opcode lookup; the bundle defaults to all-zero so each arm sets only its ones
  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_R: begin
        o_ctrl.RegWrite = 1'b1;
        o_ctrl.ALUOp    = FUNCT;
      end
      OP_I: begin
        o_ctrl.ALUSrc   = 1'b1;
        o_ctrl.RegWrite = 1'b1;
        o_ctrl.ALUOp    = FUNCT;
      end
      OP_LW: begin
        o_ctrl.ALUSrc   = 1'b1;
        o_ctrl.MemtoReg = 1'b1;
        o_ctrl.RegWrite = 1'b1;
        o_ctrl.MemRead  = 1'b1;
        o_ctrl.ALUOp    = ADD;
      end
      OP_SW: begin
        o_ctrl.ALUSrc   = 1'b1;
        o_ctrl.MemWrite = 1'b1;
        o_ctrl.ALUOp    = ADD;
      end
      OP_BR: begin
        o_ctrl.Branch   = 1'b1;
        o_ctrl.ALUOp    = BR;
      end
      OP_JAL, OP_JALR: begin
        if (EN_JUMP) begin
          o_ctrl.Jump     = 1'b1;
          o_ctrl.RegWrite = 1'b1;
          o_ctrl.ALUSrc   = (i_opcode == OP_JALR);
        end else begin
          o_ctrl.Illegal  = 1'b1;
        end
      end
      OP_LUI, OP_AUIPC: begin
        if (EN_JUMP) begin
          o_ctrl.ALUSrc   = 1'b1;
          o_ctrl.RegWrite = 1'b1;
          o_ctrl.ALUOp    = PASS;
        end else begin
          o_ctrl.Illegal  = 1'b1;
        end
      end
      default: o_ctrl.Illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control: ID/EX control register, EX/MEM memory flag, load-use
// hazard detection and a memory-wait FSM that freezes the front of the
// pipe for MEM_LAT cycles whenever a load or store enters MEM.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 0,
  parameter bit EN_JUMP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_flush,
  output ctrl_t             ex_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              mem_op,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              stall
);

  localparam logic [CNT_W-1:0] LAT_M1 = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;

  ctrl_t             w_dec;
  logic              w_mwait;
  logic              w_load_use;
  logic              w_bubble;
  logic              w_mem_next;

  ctrl_t             r_ex_ctrl;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_valid;
  logic              r_mem_op;
  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;

  main_decoder #(.EN_JUMP(EN_JUMP)) u_dec (
    .i_opcode (id_opcode),
    .o_ctrl   (w_dec)
  );

  assign w_mwait    = (r_state == MWAIT);
  // rd==x0 never creates a dependency, and an empty ID slot never stalls
  assign w_load_use = id_valid && r_ex_valid && r_ex_ctrl.MemRead &&
                      (r_ex_rd != '0) && ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
  assign w_bubble   = ex_flush || w_load_use || !id_valid;
  assign w_mem_next = r_ex_valid && (r_ex_ctrl.MemRead || r_ex_ctrl.MemWrite);

  // Memory wait dominates; a flush cancels the load-use stall it would kill anyway
  assign stall      = w_mwait || (!ex_flush && w_load_use);
  assign pc_write   = !stall;
  assign ifid_write = !stall;

  assign ex_ctrl  = r_ex_ctrl;
  assign ex_rd    = r_ex_rd;
  assign ex_valid = r_ex_valid;
  assign mem_op   = r_mem_op;

  // ID/EX register: frozen during memory wait, bubble on flush/hazard/empty ID
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_ctrl  <= '0;
      r_ex_rd    <= '0;
      r_ex_valid <= 1'b0;
    end else if (!w_mwait) begin
      if (w_bubble) begin
        r_ex_ctrl  <= '0;
        r_ex_rd    <= '0;
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_ctrl  <= w_dec;
        r_ex_rd    <= id_rd;
        r_ex_valid <= 1'b1;
      end
    end
  end

  // EX/MEM flag: marks a load/store in MEM, held while waiting on memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_op <= 1'b0;
    end else if (!w_mwait) begin
      r_mem_op <= w_mem_next;
    end
  end

  // Memory-wait FSM: each load/store entering MEM costs MEM_LAT stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if ((MEM_LAT > 0) && w_mem_next) begin
            r_state <= MWAIT;
            r_cnt   <= LAT_M1;
          end
        end
        MWAIT: begin
          if (r_cnt == '0) begin
            r_state <= RUN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule
